drum_line_bank: RTL and testbench
=================================

DRUM_LINE_BANK -- requirements
Module: drum_line_bank

Interface
REQ-001 Parameter N_LONG, default 20: number of long recirculating lines, indices 0..N_LONG-1.
REQ-002 Parameter N_SHORT, default 4: number of short lines, indices N_LONG..N_LONG+N_SHORT-1.
REQ-003 Parameter WORDS_LONG, default 108: words per long line, i.e. one drum revolution.
REQ-004 Parameter WORDS_SHORT, default 4: words per short line; WORDS_LONG SHALL be an integer multiple of WORDS_SHORT.
REQ-005 Parameter BITS, default 29: bits per word.
REQ-006 Derived widths: LW = clog2(N_LONG+N_SHORT), WW = clog2(WORDS_LONG), BW = clog2(BITS).
REQ-007 Port CLOCK  in  1: single system clock; all state SHALL change on its rising edge.
REQ-008 Port rst  in  1: reset, synchronous, active-high.
REQ-009 Port BT  in  1: bit-time enable; one drum bit-time per cycle in which BT=1.
REQ-010 Port RD_SEL  in  LW: line driving RD_BIT.
REQ-011 Port WR_SEL  in  LW: line written, and the line latched by a clear request.
REQ-012 Port WR_EN  in  1: write enable for the current bit-time.
REQ-013 Port WR_BIT  in  1: serial write data.
REQ-014 Port CLR_REQ  in  1: request to clear line WR_SEL.
REQ-015 Port RD_BIT  out  1: registered serial read data.
REQ-016 Port BIT_T  out  BW: current bit-time count.
REQ-017 Port WORD_T  out  WW: current word-time count.
REQ-018 Port T0  out  1: high while BIT_T=0 and WORD_T=0.
REQ-019 Port CLR_BUSY  out  1: high while a clear is pending or in progress.
REQ-020 Port CLR_DONE  out  1: one-cycle pulse when a clear completes.

Function
REQ-021 Timing: on each BT=1 cycle, BIT_T SHALL increment; at BITS-1 it SHALL wrap to 0 and WORD_T SHALL increment; WORD_T SHALL wrap from WORDS_LONG-1 to 0. Counters SHALL hold when BT=0.
REQ-022 Position: a long line is addressed at (WORD_T, BIT_T); a short line at (WORD_T mod WORDS_SHORT, BIT_T).
REQ-023 Read: on a BT=1 cycle, RD_BIT SHALL load the stored bit of line RD_SEL at the pre-advance position (1-cycle latency); RD_BIT SHALL hold when BT=0.
REQ-024 Write: on a BT=1 cycle with WR_EN=1, WR_BIT SHALL be stored at the pre-advance position of line WR_SEL; all other lines SHALL recirculate unchanged.
REQ-025 Read-before-write: when RD_SEL=WR_SEL on a write cycle, RD_BIT SHALL return the old stored bit.
REQ-026 Out-of-range RD_SEL (>= N_LONG+N_SHORT) SHALL read 0; out-of-range WR_SEL SHALL ignore the write and any clear request.
REQ-027 Clear FSM states: IDLE, ARM, CLEAR, DONE.
REQ-028 IDLE: on CLR_REQ=1 with an in-range WR_SEL, latch WR_SEL into CLR_LINE and go to ARM; CLR_BUSY=1 from the next cycle.
REQ-029 ARM: on the first BT=1 cycle with T0=1, write 0 at position (0,0) of CLR_LINE and go to CLEAR.
REQ-030 CLEAR: on each BT=1 cycle, write 0 to CLR_LINE; after the write at (WORDS_LONG-1, BITS-1), go to DONE. A full revolution clears a short line WORDS_LONG/WORDS_SHORT times.
REQ-031 DONE: assert CLR_DONE for exactly one cycle, deassert CLR_BUSY, return to IDLE.
REQ-032 Simultaneous write: in ARM-at-T0 or CLEAR, a WR_EN write to CLR_LINE SHALL be discarded (clear wins); writes to other lines SHALL proceed.
REQ-033 CLR_REQ SHALL be ignored outside IDLE.

Reset
REQ-034 On rst=1: BIT_T=0, WORD_T=0, RD_BIT=0, CLR_BUSY=0, CLR_DONE=0, FSM=IDLE; T0=1 after reset; a clear in progress SHALL be abandoned.
REQ-035 Line storage SHALL NOT be reset; contents persist across rst.

Verification
REQ-036 Hold BT=1 for 29*108 cycles after reset -> WORD_T goes 0..107, then T0=1 again at cycle 3132.
REQ-037 Write word 5 of line 3 with 0x1ABCDEF1, LSB first; read line 3 one revolution later -> RD_BIT serialises 0x1ABCDEF1 in word-time 5.
REQ-038 Write line 21 (short) in word-time 2 with 0x5555; read line 21 -> same pattern in word-times 2, 6, 10, ... 106.
REQ-039 CLR_REQ on line 7 at WORD_T=40 -> CLR_BUSY high; clearing starts at the next T0; CLR_DONE pulses once 3132 BT cycles later; line 7 reads all 0; WR_EN to line 8 in the same window is stored.
REQ-040 rst asserted mid-CLEAR -> CLR_BUSY=0, counters 0, no CLR_DONE pulse; bits not yet cleared keep their prior values.
REQ-041 RD_SEL=WR_SEL=2 with WR_EN=1 -> RD_BIT shows old data this revolution and new data the next; RD_SEL=24 -> RD_BIT=0.

Source files
------------

// File: rtl/drum_line_bank.sv
// Bank of serial recirculating drum lines (long + short) with a revolution-aligned line-clear engine.
// Timing counters advance per bit-time; RD_BIT is registered (1-cycle latency); no backpressure, BT gates all progress.
module drum_line_bank #(
  parameter int N_LONG      = 20,
  parameter int N_SHORT     = 4,
  parameter int WORDS_LONG  = 108,
  parameter int WORDS_SHORT = 4,
  parameter int BITS        = 29,
  localparam int LW = $clog2(N_LONG + N_SHORT),
  localparam int WW = $clog2(WORDS_LONG),
  localparam int BW = $clog2(BITS)
) (
  input  logic          CLOCK,
  input  logic          rst,
  input  logic          BT,
  input  logic [LW-1:0] RD_SEL,
  input  logic [LW-1:0] WR_SEL,
  input  logic          WR_EN,
  input  logic          WR_BIT,
  input  logic          CLR_REQ,
  output logic          RD_BIT,
  output logic [BW-1:0] BIT_T,
  output logic [WW-1:0] WORD_T,
  output logic          T0,
  output logic          CLR_BUSY,
  output logic          CLR_DONE
);

  localparam int NLINES = N_LONG + N_SHORT;
  localparam int LIW    = (N_LONG > 1) ? $clog2(N_LONG) : 1;
  localparam int SIW    = (N_SHORT > 1) ? $clog2(N_SHORT) : 1;
  localparam int SWW    = (WORDS_SHORT > 1) ? $clog2(WORDS_SHORT) : 1;

  typedef enum logic [1:0] {IDLE, ARM, CLEAR, DONE} clr_state_t;

  clr_state_t state, state_nxt;
  logic [LW-1:0] clr_line;
  logic          clr_we;
  logic          last_pos;

  logic [BITS-1:0] long_mem  [N_LONG][WORDS_LONG];
  logic [BITS-1:0] short_mem [N_SHORT][WORDS_SHORT];
  logic [SWW-1:0]  short_word;

  logic rd_long, rd_short, wr_long, wr_short, clr_long, clr_short;
  logic wr_ok, rd_val;

  function automatic logic in_long(input logic [LW-1:0] sel);
    return sel < LW'(N_LONG);
  endfunction

  // Compared one bit wider so a power-of-two line count cannot wrap to zero.
  function automatic logic in_short(input logic [LW-1:0] sel);
    return (sel >= LW'(N_LONG)) && ({1'b0, sel} < (LW+1)'(NLINES));
  endfunction

  function automatic logic [LIW-1:0] long_idx(input logic [LW-1:0] sel);
    return LIW'(sel);
  endfunction

  function automatic logic [SIW-1:0] short_idx(input logic [LW-1:0] sel);
    return SIW'(sel - LW'(N_LONG));
  endfunction

  assign short_word = SWW'(WORD_T % WW'(WORDS_SHORT));
  assign T0         = (BIT_T == '0) && (WORD_T == '0);
  assign last_pos   = (BIT_T == BW'(BITS - 1)) && (WORD_T == WW'(WORDS_LONG - 1));

  assign rd_long   = in_long(RD_SEL);
  assign rd_short  = in_short(RD_SEL);
  assign wr_long   = in_long(WR_SEL);
  assign wr_short  = in_short(WR_SEL);
  assign clr_long  = in_long(clr_line);
  assign clr_short = in_short(clr_line);

  // A user write colliding with the line being cleared loses to the clear.
  assign wr_ok = BT && WR_EN && (wr_long || wr_short) &&
                 !(clr_we && (WR_SEL == clr_line));

  always_comb begin
    rd_val = 1'b0;
    if (rd_long) begin
      rd_val = long_mem[long_idx(RD_SEL)][WORD_T][BIT_T];
    end else if (rd_short) begin
      rd_val = short_mem[short_idx(RD_SEL)][short_word][BIT_T];
    end
  end

  // Storage has no reset: contents survive rst.
  always_ff @(posedge CLOCK) begin
    if (!rst && wr_ok && wr_long) begin
      long_mem[long_idx(WR_SEL)][WORD_T][BIT_T] <= WR_BIT;
    end
    if (!rst && wr_ok && wr_short) begin
      short_mem[short_idx(WR_SEL)][short_word][BIT_T] <= WR_BIT;
    end
    if (!rst && clr_we && clr_long) begin
      long_mem[long_idx(clr_line)][WORD_T][BIT_T] <= 1'b0;
    end
    if (!rst && clr_we && clr_short) begin
      short_mem[short_idx(clr_line)][short_word][BIT_T] <= 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      BIT_T  <= '0;
      WORD_T <= '0;
    end else if (BT) begin
      if (BIT_T == BW'(BITS - 1)) begin
        BIT_T  <= '0;
        WORD_T <= (WORD_T == WW'(WORDS_LONG - 1)) ? '0 : WORD_T + 1'b1;
      end else begin
        BIT_T <= BIT_T + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      RD_BIT <= 1'b0;
    end else if (BT) begin
      RD_BIT <= rd_val;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state    <= IDLE;
      clr_line <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && CLR_REQ && (wr_long || wr_short)) begin
        clr_line <= WR_SEL;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    CLR_BUSY  = 1'b0;
    CLR_DONE  = 1'b0;
    case (state)
      IDLE: begin
        if (CLR_REQ && (wr_long || wr_short)) state_nxt = ARM;
      end
      ARM: begin
        CLR_BUSY = 1'b1;
        if (BT && T0) begin
          clr_we    = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        CLR_BUSY = 1'b1;
        if (BT) begin
          clr_we = 1'b1;
          if (last_pos) state_nxt = DONE;
        end
      end
      DONE: begin
        CLR_DONE  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_drum_line_bank.sv
// Bench for drum_line_bank: reset/counter vector table, directed revolution sequences, then random traffic vs a position-based model.
module tb_drum_line_bank;

  localparam int NL  = 24;
  localparam int WL  = 108;
  localparam int NB  = 29;
  localparam int REV = WL * NB;

  logic       CLOCK   = 1'b0;
  logic       rst     = 1'b0;
  logic       BT      = 1'b0;
  logic [4:0] RD_SEL  = '0;
  logic [4:0] WR_SEL  = '0;
  logic       WR_EN   = 1'b0;
  logic       WR_BIT  = 1'b0;
  logic       CLR_REQ = 1'b0;
  logic       RD_BIT;
  logic [4:0] BIT_T;
  logic [6:0] WORD_T;
  logic       T0, CLR_BUSY, CLR_DONE;

  drum_line_bank dut (
    .CLOCK(CLOCK), .rst(rst), .BT(BT), .RD_SEL(RD_SEL), .WR_SEL(WR_SEL),
    .WR_EN(WR_EN), .WR_BIT(WR_BIT), .CLR_REQ(CLR_REQ), .RD_BIT(RD_BIT),
    .BIT_T(BIT_T), .WORD_T(WORD_T), .T0(T0), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference state: drum position as a single bit-time index within one revolution.
  bit mem   [NL][WL][NB];
  bit known [NL][WL][NB];
  int m_pos = 0;
  bit m_rd = 1'b0, m_rd_known = 1'b0;
  bit c_pend = 1'b0, c_act = 1'b0, c_done = 1'b0;
  int c_line = 0;
  int nchk = 0, npass = 0;

  function automatic int mword(input int line, input int w);
    return (line < 20) ? w : (w % 4);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    int w, b, rs, ws;
    bit idle, new_done, clearing;
    if (rst) begin
      m_pos = 0; m_rd = 1'b0; m_rd_known = 1'b1;
      c_pend = 1'b0; c_act = 1'b0; c_done = 1'b0;
      return;
    end
    rs = int'(RD_SEL);
    ws = int'(WR_SEL);
    idle = !c_pend && !c_act && !c_done;
    new_done = 1'b0;
    if (BT) begin
      w = m_pos / NB;
      b = m_pos % NB;
      if (rs < NL) begin
        m_rd = mem[rs][mword(rs, w)][b];
        m_rd_known = known[rs][mword(rs, w)][b];
      end else begin
        m_rd = 1'b0; m_rd_known = 1'b1;
      end
      clearing = (c_pend && m_pos == 0) || c_act;
      if (clearing) begin
        mem[c_line][mword(c_line, w)][b] = 1'b0;
        known[c_line][mword(c_line, w)][b] = 1'b1;
        c_pend = 1'b0;
        c_act = (m_pos != REV - 1);
        new_done = (m_pos == REV - 1);
      end
      if (WR_EN && ws < NL && !(clearing && ws == c_line)) begin
        mem[ws][mword(ws, w)][b] = WR_BIT;
        known[ws][mword(ws, w)][b] = 1'b1;
      end
      m_pos = (m_pos + 1) % REV;
    end
    c_done = new_done;
    if (idle && CLR_REQ && ws < NL) begin
      c_pend = 1'b1;
      c_line = ws;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_step();
    #1;
    chk("bit_t", int'(BIT_T), m_pos % NB);
    chk("word_t", int'(WORD_T), m_pos / NB);
    chk("t0", int'(T0), int'(m_pos == 0));
    chk("clr_busy", int'(CLR_BUSY), int'(c_pend || c_act));
    chk("clr_done", int'(CLR_DONE), int'(c_done));
    if (m_rd_known) chk("rd_bit", int'(RD_BIT), int'(m_rd));
  endtask

  typedef struct {
    bit rst;
    bit bt;
    int e_bit;
    int e_word;
    int e_t0;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the test ended");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    logic [28:0] p3, p21, pa, pb, p8, acc;
    int w, b, ndone, nclr, ones;
    bit started;

    p3 = 29'h1ABCDEF1; p21 = 29'h0005555; pa = 29'h0F0F0F0F;
    pb = 29'h1234567;  p8 = 29'h0ACE135;  acc = '0;

    vt[0] = '{1'b1, 1'b1, 0, 0, 1};
    vt[1] = '{1'b0, 1'b1, 1, 0, 0};
    vt[2] = '{1'b0, 1'b1, 2, 0, 0};
    vt[3] = '{1'b0, 1'b0, 2, 0, 0};
    vt[4] = '{1'b0, 1'b0, 2, 0, 0};
    vt[5] = '{1'b0, 1'b1, 3, 0, 0};
    vt[6] = '{1'b1, 1'b1, 0, 0, 1};
    vt[7] = '{1'b0, 1'b0, 0, 0, 1};

    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst;
      BT  = vt[i].bt;
      tick();
      chk("vec_bit_t", int'(BIT_T), vt[i].e_bit);
      chk("vec_word_t", int'(WORD_T), vt[i].e_word);
      chk("vec_t0", int'(T0), vt[i].e_t0);
      if (vt[i].rst) begin
        chk("vec_rd_reset", int'(RD_BIT), 0);
        chk("vec_busy_reset", int'(CLR_BUSY), 0);
        chk("vec_done_reset", int'(CLR_DONE), 0);
      end
    end
    rst = 1'b0;
    BT  = 1'b1;

    // Revolution A: write line 3 word 5, line 21 word 2, line 2 word 11; check period.
    for (int k = 1; k <= REV; k++) begin
      w = m_pos / NB; b = m_pos % NB;
      WR_EN = 1'b1;
      if (w == 5)       begin WR_SEL = 5'd3;  WR_BIT = p3[b];  end
      else if (w == 2)  begin WR_SEL = 5'd21; WR_BIT = p21[b]; end
      else if (w == 11) begin WR_SEL = 5'd2;  WR_BIT = pa[b];  end
      else WR_EN = 1'b0;
      tick();
      if (k == REV - 1) chk("word_t_last", int'(WORD_T), WL - 1);
      if (k == REV || k == 1 || k == NB) chk("t0_period", int'(T0), int'(k == REV));
    end

    // Revolution B: read back; overwrite line 2 word 11 while reading it.
    for (int k = 0; k < REV; k++) begin
      w = m_pos / NB; b = m_pos % NB;
      RD_SEL = (w == 5) ? 5'd3 : ((w == 11) ? 5'd2 : 5'd21);
      WR_EN  = (w == 11);
      WR_SEL = 5'd2;
      WR_BIT = pb[b];
      tick();
      acc[b] = RD_BIT;
      if (b == NB - 1) begin
        if (w == 5) chk("line3_word5", int'(acc), int'(p3));
        else if (w == 11) chk("rbw_old", int'(acc), int'(pa));
        else if (w % 4 == 2) chk("line21_repeat", int'(acc), int'(p21));
      end
    end

    // Revolution C: new data on line 2, out-of-range read, fill line 7 with ones.
    for (int k = 0; k < REV; k++) begin
      w = m_pos / NB; b = m_pos % NB;
      RD_SEL = (w == 20) ? 5'd24 : 5'd2;
      WR_EN = 1'b1; WR_SEL = 5'd7; WR_BIT = 1'b1;
      tick();
      acc[b] = RD_BIT;
      if (w == 11 && b == NB - 1) chk("rbw_new", int'(acc), int'(pb));
      if (w == 20 && b == 3) chk("rd_out_of_range", int'(RD_BIT), 0);
    end

    // Clear line 7, requested at word-time 40.
    WR_EN = 1'b0;
    while (m_pos != 40 * NB) tick();
    CLR_REQ = 1'b1; WR_SEL = 5'd7;
    tick();
    CLR_REQ = 1'b0;
    chk("clr_busy_after_req", int'(CLR_BUSY), 1);
    ndone = 0; nclr = 0; started = 1'b0;
    for (int k = 0; k < 8000 && ndone == 0; k++) begin
      w = m_pos / NB; b = m_pos % NB;
      if (m_pos == 0) started = 1'b1;
      if (started) nclr++;
      WR_EN = 1'b1;
      if (w == 50)                 begin WR_SEL = 5'd8; WR_BIT = p8[b]; end
      else if (w == 60 && started) begin WR_SEL = 5'd7; WR_BIT = 1'b1;  end
      else                         begin WR_SEL = 5'd9; WR_BIT = 1'b1;  end
      tick();
      if (CLR_DONE) ndone++;
    end
    chk("clr_done_seen", ndone, 1);
    chk("clr_length", nclr, REV);
    WR_EN = 1'b0;
    while (m_pos != 0) tick();

    ones = 0;
    RD_SEL = 5'd7;
    for (int k = 0; k < REV; k++) begin
      tick();
      ones += int'(RD_BIT);
      if (CLR_DONE) ndone++;
    end
    chk("line7_cleared", ones, 0);
    chk("clr_done_once", ndone, 1);

    ones = 0;
    for (int k = 0; k < REV; k++) begin
      w = m_pos / NB; b = m_pos % NB;
      RD_SEL = (w == 50) ? 5'd8 : 5'd9;
      tick();
      if (w == 50) acc[b] = RD_BIT;
      else ones += int'(RD_BIT);
    end
    chk("line8_written_during_clear", int'(acc), int'(p8));
    chk("line9_ones", ones, (WL - 1) * NB);

    // Abandon a clear of line 9 after 1000 bit-times with rst.
    while (m_pos != REV - 1) tick();
    CLR_REQ = 1'b1; WR_SEL = 5'd9;
    tick();
    CLR_REQ = 1'b0;
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", int'(CLR_BUSY), 0);
    chk("rst_bit_t", int'(BIT_T), 0);
    chk("rst_word_t", int'(WORD_T), 0);
    chk("rst_rd_bit", int'(RD_BIT), 0);
    ones = 0; ndone = 0;
    RD_SEL = 5'd9;
    for (int k = 0; k < REV; k++) begin
      w = m_pos / NB;
      tick();
      if (w != 50) ones += int'(RD_BIT);
      if (CLR_DONE) ndone++;
    end
    chk("partial_clear_ones", ones, REV - 1000 - NB);
    chk("no_done_after_rst", ndone, 0);

    // Random traffic against the model.
    for (int k = 0; k < 6000; k++) begin
      BT      = ($urandom_range(0, 3) != 0);
      RD_SEL  = 5'($urandom_range(0, 25));
      WR_SEL  = 5'($urandom_range(0, 25));
      WR_EN   = $urandom_range(0, 1) == 1;
      WR_BIT  = $urandom_range(0, 1) == 1;
      CLR_REQ = ($urandom_range(0, 199) == 0);
      rst     = ($urandom_range(0, 2999) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
